// File: rtl/vit_3by4_dec_trb_sched_pkg.sv
// Shared types for the 3/4 Viterbi traceback command scheduler:
// command record, arrival stamp and the wrap-safe age comparison.
package vit_3by4_trb_sched_pkg;

  localparam int ADDR_W   = 8;
  localparam int STATE_W  = 6;
  localparam int QDEPTH_W = 2;
  localparam int STAMP_W  = QDEPTH_W + 2;

  typedef struct packed {
    logic [ADDR_W-1:0]  raddr;
    logic [ADDR_W-1:0]  size_m1;
    logic [STATE_W-1:0] state;
  } trb_cmd_t;

  typedef logic [STAMP_W-1:0] stamp_t;

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} sched_state_t;

  // True when the regular head is older than or as old as the flush head.
  // Safe across wrap because outstanding entries never span half the stamp range.
  function automatic logic regular_first(stamp_t stamp_s, stamp_t stamp_f);
    stamp_t diff;
    diff = stamp_s - stamp_f;
    return diff[STAMP_W-1] || (diff == '0);
  endfunction

endpackage

// File: rtl/vit_trb_cmd_fifo.sv
// Small register FIFO with first-word-fall-through head; a push onto a full
// queue is only taken when the same cycle also pops.
module vit_trb_cmd_fifo #(
  parameter int pW       = 26,
  parameter int pDEPTH_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          push,
  input  logic          pop,
  input  logic [pW-1:0] din,
  output logic [pW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic          accept,
  output logic          pending
);

  localparam int DEPTH = 1 << pDEPTH_W;

  logic [pW-1:0]       mem [DEPTH];
  logic [pDEPTH_W-1:0] wptr;
  logic [pDEPTH_W-1:0] rptr;
  logic [pDEPTH_W:0]   count;
  logic [pDEPTH_W:0]   count_nxt;
  logic                do_pop;

  assign full    = (count == (pDEPTH_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = ena & pop & ~empty;
  assign accept  = ena & push & (~full | do_pop);
  assign dout    = mem[rptr];
  // pending is the occupancy the queue will have after this edge
  assign pending = (count_nxt != '0);

  always_comb begin
    count_nxt = count + {{pDEPTH_W{1'b0}}, accept} - {{pDEPTH_W{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= din;
  end

endmodule

// File: rtl/vit_3by4_dec_trb_sched.sv
// Traceback command scheduler: queues regular and flush requests separately
// and issues them to the traceback engine one at a time in arrival order.
module vit_3by4_dec_trb_sched
  import vit_3by4_trb_sched_pkg::*;
#(
  parameter int pADDR_W   = 8,
  parameter int pSTATE_W  = 6,
  parameter int pQDEPTH_W = 2,
  parameter int pHOLDOFF  = 2
) (
  input  logic                iclk,
  input  logic                ireset,
  input  logic                iclkena,
  input  logic                istart,
  input  logic [pADDR_W-1:0]  iraddr,
  input  logic [pADDR_W-1:0]  isize_m1,
  input  logic [pSTATE_W-1:0] istate,
  input  logic                iflush,
  input  logic [pADDR_W-1:0]  ifraddr,
  input  logic [pADDR_W-1:0]  ifsize_m1,
  input  logic [pSTATE_W-1:0] ifstate,
  input  logic                iengine_rdy,
  output logic                ostart,
  output logic                oflush,
  output logic [pADDR_W-1:0]  oraddr,
  output logic [pADDR_W-1:0]  osize_m1,
  output logic [pSTATE_W-1:0] ostate,
  output logic                obusy,
  output logic                ooverflow
);

  localparam int EW  = $bits(trb_cmd_t) + STAMP_W;
  localparam int HCW = (pHOLDOFF > 2) ? $clog2(pHOLDOFF) : 1;

  sched_state_t   state;
  stamp_t         stamp;
  stamp_t         s_stamp, f_stamp;
  trb_cmd_t       s_cmd, f_cmd, s_head, f_head;
  logic [EW-1:0]  s_din, f_din, s_dout, f_dout;
  logic           s_full, f_full, s_empty, f_empty;
  logic           s_acc, f_acc, s_pend, f_pend;
  logic           s_pop, f_pop;
  logic           can_issue, sel_s, q_pend;
  logic [HCW-1:0] hold_cnt;

  // Both requests of a same-cycle pair carry the current stamp
  assign s_cmd = {iraddr, isize_m1, istate};
  assign f_cmd = {ifraddr, ifsize_m1, ifstate};
  assign s_din = {s_cmd, stamp};
  assign f_din = {f_cmd, stamp};
  assign {s_head, s_stamp} = s_dout;
  assign {f_head, f_stamp} = f_dout;

  assign can_issue = iclkena & (state == IDLE) & iengine_rdy & (~s_empty | ~f_empty);
  assign sel_s     = ~s_empty & (f_empty | regular_first(s_stamp, f_stamp));
  assign s_pop     = can_issue & sel_s;
  assign f_pop     = can_issue & ~sel_s;
  assign q_pend    = s_pend | f_pend;

  vit_trb_cmd_fifo #(.pW(EW), .pDEPTH_W(pQDEPTH_W)) u_reg_q (
    .clk(iclk), .rst(ireset), .ena(iclkena), .push(istart), .pop(s_pop),
    .din(s_din), .dout(s_dout), .full(s_full), .empty(s_empty),
    .accept(s_acc), .pending(s_pend)
  );

  vit_trb_cmd_fifo #(.pW(EW), .pDEPTH_W(pQDEPTH_W)) u_flush_q (
    .clk(iclk), .rst(ireset), .ena(iclkena), .push(iflush), .pop(f_pop),
    .din(f_din), .dout(f_dout), .full(f_full), .empty(f_empty),
    .accept(f_acc), .pending(f_pend)
  );

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state     <= IDLE;
      stamp     <= '0;
      hold_cnt  <= '0;
      ostart    <= 1'b0;
      oflush    <= 1'b0;
      oraddr    <= '0;
      osize_m1  <= '0;
      ostate    <= '0;
      obusy     <= 1'b0;
      ooverflow <= 1'b0;
    end else if (iclkena) begin
      if (s_acc | f_acc) stamp <= stamp + 1'b1;
      if ((istart & s_full & ~s_pop) | (iflush & f_full & ~f_pop)) ooverflow <= 1'b1;
      ostart <= 1'b0;
      oflush <= 1'b0;
      // obusy is loaded with the occupancy/state that holds after this edge
      case (state)
        IDLE: begin
          if (can_issue) begin
            ostart <= sel_s;
            oflush <= ~sel_s;
            {oraddr, osize_m1, ostate} <= sel_s ? s_head : f_head;
            state  <= ISSUE;
            obusy  <= 1'b1;
          end else begin
            obusy <= q_pend;
          end
        end
        ISSUE: begin
          if (pHOLDOFF > 1) begin
            state    <= HOLD;
            hold_cnt <= HCW'(pHOLDOFF - 2);
            obusy    <= 1'b1;
          end else begin
            state <= IDLE;
            obusy <= q_pend;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state <= IDLE;
            obusy <= q_pend;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
            obusy    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          obusy <= q_pend;
        end
      endcase
    end
  end

endmodule
